// File: rtl/nco_freq_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// nco_freq_sweep_ctrl
//
// Avalon-MM controlled frequency-word sequencer for the DDS NCO. The block
// either applies a single frequency word or steps linearly from a start word
// by a signed step. Each word is held for a programmable dwell time. Every
// change of freq_word is accompanied by a one-cycle freq_valid strobe, so the
// NCO can latch the word without glitches.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   address    register select (0 CTRL, 1 START_FREQ, 2 STEP, 3 COUNT,
//              4 DWELL, 5 CURRENT, 6/7 read as zero)
//   chipselect Avalon slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   combinational read mux, zero-extended
//   freq_word  frequency word to the NCO
//   freq_valid one-cycle pulse whenever freq_word changes
//   busy       sweep in progress
//   irq        level interrupt, registered copy of done & IRQ_EN
//
// Handshake: the bus side has no wait states. A write takes effect on the
// clock edge where chipselect=1 and write_n=0. freq_valid has no ready: it is
// a strobe that is high for exactly the cycle in which a new freq_word is
// first presented.
// -----------------------------------------------------------------------------
module nco_freq_sweep_ctrl #(
  parameter int FREQ_W      = 22,
  parameter int START_RESET = 593410,
  parameter int DWELL_W     = 24,
  parameter int COUNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [FREQ_W-1:0] freq_word,
  output logic              freq_valid,
  output logic              busy,
  output logic              irq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_STEP  = 2'd2
  } state_t;

  localparam logic [FREQ_W-1:0] FREQ_RST = FREQ_W'(START_RESET);

  // Bus decode
  logic wr;
  logic ctrl_wr;
  logic start_req;
  logic abort_req;
  logic done_clr;

  assign wr        = chipselect & ~write_n;
  assign ctrl_wr   = wr && (address == 3'd0);
  assign start_req = ctrl_wr & writedata[0];
  assign abort_req = ctrl_wr & writedata[1];
  assign done_clr  = ctrl_wr & writedata[3];

  // The upper writedata bits have no register behind them.
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:DWELL_W];

  // Configuration registers (bus visible)
  logic [FREQ_W-1:0]  start_freq_q;
  logic [FREQ_W-1:0]  step_q;
  logic [COUNT_W-1:0] count_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               loop_q;
  logic               irq_en_q;

  // Shadow copies taken at START so that config writes during a sweep only
  // affect the next sweep.
  logic [FREQ_W-1:0]  sh_start_q;
  logic [FREQ_W-1:0]  sh_step_q;
  logic [COUNT_W-1:0] sh_count_q;
  logic [DWELL_W-1:0] sh_dwell_q;

  // Sequencer state
  state_t             state_q, state_d;
  logic [FREQ_W-1:0]  freq_q, freq_d;
  logic               valid_q, valid_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [COUNT_W-1:0] steps_left_q, steps_left_d;
  logic               done_q, done_d;
  logic               irq_q;
  logic               load_shadow;

  // A dwell of zero behaves like a dwell of one: a word is never held
  // for less than one clock.
  function automatic logic [DWELL_W-1:0] dwell_reload(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  // Configuration register writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_freq_q <= FREQ_RST;
      step_q       <= '0;
      count_q      <= '0;
      dwell_q      <= '0;
      loop_q       <= 1'b0;
      irq_en_q     <= 1'b0;
    end else if (wr) begin
      case (address)
        3'd0: begin
          loop_q   <= writedata[2];
          irq_en_q <= writedata[4];
        end
        3'd1:    start_freq_q <= writedata[FREQ_W-1:0];
        3'd2:    step_q       <= writedata[FREQ_W-1:0];
        3'd3:    count_q      <= writedata[COUNT_W-1:0];
        3'd4:    dwell_q      <= writedata[DWELL_W-1:0];
        default: ;
      endcase
    end
  end

  // Shadow registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_start_q <= FREQ_RST;
      sh_step_q  <= '0;
      sh_count_q <= '0;
      sh_dwell_q <= '0;
    end else if (load_shadow) begin
      sh_start_q <= start_freq_q;
      sh_step_q  <= step_q;
      sh_count_q <= count_q;
      sh_dwell_q <= dwell_q;
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      freq_q       <= FREQ_RST;
      valid_q      <= 1'b0;
      dwell_cnt_q  <= '0;
      steps_left_q <= '0;
      done_q       <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      freq_q       <= freq_d;
      valid_q      <= valid_d;
      dwell_cnt_q  <= dwell_cnt_d;
      steps_left_q <= steps_left_d;
      done_q       <= done_d;
      irq_q        <= done_q & irq_en_q;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d      = state_q;
    freq_d       = freq_q;
    valid_d      = 1'b0;
    dwell_cnt_d  = dwell_cnt_q;
    steps_left_d = steps_left_q;
    done_d       = done_q;
    load_shadow  = 1'b0;

    // Clear first so that a done being set on the same edge overrides it.
    if (done_clr) begin
      done_d = 1'b0;
    end

    if (abort_req) begin
      // ABORT beats everything, including a START in the same write.
      // The word and done are left alone and no strobe is issued.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_req) begin
            load_shadow  = 1'b1;
            freq_d       = start_freq_q;
            valid_d      = 1'b1;
            dwell_cnt_d  = dwell_reload(dwell_q);
            steps_left_d = count_q;
            state_d      = S_DWELL;
          end else if (wr && (address == 3'd1)) begin
            // While idle, START_FREQ acts as a direct frequency write.
            freq_d  = writedata[FREQ_W-1:0];
            valid_d = 1'b1;
          end
        end

        S_DWELL: begin
          if (dwell_cnt_q != '0) begin
            dwell_cnt_d = dwell_cnt_q - 1'b1;
          end else if (steps_left_q != '0) begin
            state_d = S_STEP;
          end else if (loop_q) begin
            freq_d       = sh_start_q;
            valid_d      = 1'b1;
            steps_left_d = sh_count_q;
            dwell_cnt_d  = dwell_reload(sh_dwell_q);
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end

        S_STEP: begin
          // Modular add: the step wraps around the word width.
          freq_d       = freq_q + sh_step_q;
          valid_d      = 1'b1;
          steps_left_d = steps_left_q - 1'b1;
          dwell_cnt_d  = dwell_reload(sh_dwell_q);
          state_d      = S_DWELL;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // Read mux
  always_comb begin
    readdata = '0;
    case (address)
      3'd0: begin
        readdata[0] = busy;
        readdata[1] = done_q;
        readdata[2] = loop_q;
        readdata[4] = irq_en_q;
      end
      3'd1:    readdata[FREQ_W-1:0]  = start_freq_q;
      3'd2:    readdata[FREQ_W-1:0]  = step_q;
      3'd3:    readdata[COUNT_W-1:0] = count_q;
      3'd4:    readdata[DWELL_W-1:0] = dwell_q;
      3'd5:    readdata[FREQ_W-1:0]  = freq_q;
      default: readdata = '0;
    endcase
  end

  assign freq_word  = freq_q;
  assign freq_valid = valid_q;
  assign busy       = (state_q != S_IDLE);
  assign irq        = irq_q;

endmodule

// File: tb/tb_nco_freq_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nco_freq_sweep_ctrl
//
// Directed and randomized checks of nco_freq_sweep_ctrl. A monitor records
// every freq_valid pulse (cycle number and word). A reference model computes
// the expected pulse list from the sweep parameters:
//   word k  = (start + k*step) mod 2^22
//   time k  = t0 + k*(max(DWELL,1)+1)
//   done at t0 + COUNT*(max(DWELL,1)+1) + max(DWELL,1)
// -----------------------------------------------------------------------------
module tb_nco_freq_sweep_ctrl;

  localparam int RST_WORD = 593410;
  localparam int BOUND    = 3000;

  // Clock and reset
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [21:0] freq_word;
  logic        freq_valid;
  logic        busy;
  logic        irq;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  nco_freq_sweep_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .freq_word  (freq_word),
    .freq_valid (freq_valid),
    .busy       (busy),
    .irq        (irq)
  );

  // Monitor: every strobe with its cycle stamp
  logic [21:0] got_w[$];
  int          got_t[$];

  always @(negedge clk) begin
    if (freq_valid === 1'b1) begin
      got_w.push_back(freq_word);
      got_t.push_back(cyc);
    end
  end

  // Scoreboard
  logic [21:0] exp_q[$];
  int          exp_t[$];
  int          tests = 0;
  int          fails = 0;

  // Current sweep parameters for the model
  logic [21:0] m_s;
  logic [21:0] m_st;
  int          m_c;
  int          m_d;
  int          m_t0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic read_check(input logic [2:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    address = a;
    #1;
    check(tag, 64'(readdata), 64'(exp));
  endtask

  // Reference model
  function automatic void build_exp(input bit lp, input longint limit);
    int dd;
    int p;
    int len;
    exp_q.delete();
    exp_t.delete();
    dd  = (m_d == 0) ? 1 : m_d;
    p   = dd + 1;
    len = m_c * p + dd;
    for (int r = 0; r < 1000; r++) begin
      for (int k = 0; k <= m_c; k++) begin
        longint t;
        longint w;
        t = longint'(m_t0) + longint'(r) * longint'(len) + longint'(k) * longint'(p);
        if (t >= limit) return;
        w = (longint'(m_s) + longint'(k) * longint'(m_st)) & 64'h3FFFFF;
        exp_q.push_back(22'(w));
        exp_t.push_back(int'(t));
      end
      if (!lp) return;
    end
  endfunction

  task automatic compare_pulses(input string tag);
    check({tag, "_npulse"}, 64'(got_w.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_w.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_word%0d", tag, i), 64'(got_w[i]), 64'(exp_q[i]));
      check($sformatf("%s_time%0d", tag, i), 64'(got_t[i]), 64'(exp_t[i]));
    end
  endtask

  task automatic program_sweep(input logic [21:0] s, input logic [21:0] st,
                               input int c, input int d);
    write_reg(3'd0, 32'h8);
    write_reg(3'd1, 32'(s));
    write_reg(3'd2, 32'(st));
    write_reg(3'd3, 32'(c));
    write_reg(3'd4, 32'(d));
    m_s  = s;
    m_st = st;
    m_c  = c;
    m_d  = d;
  endtask

  task automatic start_sweep(input logic [31:0] bits);
    got_w.delete();
    got_t.delete();
    write_reg(3'd0, bits | 32'h1);
    m_t0 = cyc;
  endtask

  task automatic finish_sweep(input string tag, input bit ien);
    int n;
    int dd;
    n = 0;
    while (busy === 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 64'(n < BOUND), 64'(1));
    dd = (m_d == 0) ? 1 : m_d;
    check({tag, "_done_time"}, 64'(cyc), 64'(m_t0 + m_c * (dd + 1) + dd));
    build_exp(1'b0, 64'h7FFF_FFFF_FFFF);
    compare_pulses(tag);
    repeat (2) @(negedge clk);
    check({tag, "_irq"}, 64'(irq), 64'(ien));
    read_check(3'd0, (32'(ien) << 4) | 32'h2, {tag, "_ctrl"});
  endtask

  // Directed sequence
  initial begin
    logic [21:0] fw;
    int          ta;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_freq_word", 64'(freq_word), 64'(RST_WORD));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_irq", 64'(irq), 64'(0));
    check("rst_valid", 64'(freq_valid), 64'(0));
    read_check(3'd5, 32'(RST_WORD), "rst_current");
    read_check(3'd1, 32'(RST_WORD), "rst_start_freq");
    read_check(3'd0, 32'h0, "rst_ctrl");
    read_check(3'd2, 32'h0, "rst_step");
    read_check(3'd6, 32'h0, "rd_addr6");
    read_check(3'd7, 32'h0, "rd_addr7");

    // Idle direct frequency write
    got_w.delete();
    got_t.delete();
    write_reg(3'd1, 32'h0010_0000);
    ta = cyc;
    check("idle_wr_word", 64'(freq_word), 64'h10_0000);
    repeat (3) @(negedge clk);
    check("idle_wr_npulse", 64'(got_w.size()), 64'(1));
    if (got_w.size() > 0) begin
      check("idle_wr_pulse_word", 64'(got_w[0]), 64'h10_0000);
      check("idle_wr_pulse_time", 64'(got_t[0]), 64'(ta));
    end
    read_check(3'd1, 32'h0010_0000, "idle_wr_readback");

    // Linear sweep with interrupt
    program_sweep(22'd1000, 22'd10, 3, 4);
    start_sweep(32'h10);
    finish_sweep("lin", 1'b1);
    write_reg(3'd0, 32'h18);
    repeat (2) @(negedge clk);
    check("lin_irq_clr", 64'(irq), 64'(0));
    read_check(3'd0, 32'h10, "lin_ctrl_clr");

    // Wrap-around in both directions
    program_sweep(22'h3FFFF8, 22'h000010, 1, 1);
    start_sweep(32'h0);
    finish_sweep("wrap_up", 1'b0);
    check("wrap_up_last", 64'(freq_word), 64'h8);
    program_sweep(22'd5, 22'h3FFFF0, 1, 0);
    start_sweep(32'h0);
    finish_sweep("wrap_dn", 1'b0);
    check("wrap_dn_last", 64'(freq_word), 64'h3FFFF5);

    // Randomized sweeps, including COUNT=0 and DWELL=0
    for (int i = 0; i < 8; i++) begin
      logic ien;
      ien = 1'($urandom_range(0, 1));
      program_sweep(22'($urandom), 22'($urandom),
                    $urandom_range(0, 4), $urandom_range(0, 5));
      start_sweep(32'(ien) << 4);
      finish_sweep($sformatf("rnd%0d", i), ien);
    end

    // Looping sweep cut short by ABORT
    program_sweep(22'($urandom), 22'($urandom), 1, 2);
    start_sweep(32'h4);
    repeat ($urandom_range(10, 20)) @(negedge clk);
    write_reg(3'd0, 32'h2);
    ta = cyc;
    check("loop_abort_busy", 64'(busy), 64'(0));
    repeat (4) @(negedge clk);
    build_exp(1'b1, longint'(ta));
    compare_pulses("loop");
    check("loop_abort_hold", 64'(freq_word), 64'(exp_q[exp_q.size() - 1]));
    read_check(3'd0, 32'h0, "loop_abort_ctrl");

    // START together with ABORT stays idle
    got_w.delete();
    got_t.delete();
    fw = freq_word;
    write_reg(3'd0, 32'h3);
    check("start_abort_busy", 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
    check("start_abort_npulse", 64'(got_w.size()), 64'(0));
    check("start_abort_word", 64'(freq_word), 64'(fw));

    // START and START_FREQ writes while busy do not disturb the sweep
    program_sweep(22'd2000, 22'h3FFFFB, 3, 3);
    start_sweep(32'h0);
    repeat (3) @(negedge clk);
    write_reg(3'd1, 32'h0000_1234);
    write_reg(3'd0, 32'h1);
    finish_sweep("busy_start", 1'b0);
    read_check(3'd1, 32'h0000_1234, "busy_start_freq_reg");

    // Asynchronous reset in the middle of a sweep
    program_sweep(22'd100, 22'd1, 4, 3);
    start_sweep(32'h10);
    repeat (5) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_freq_word", 64'(freq_word), 64'(RST_WORD));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_valid", 64'(freq_valid), 64'(0));
    check("arst_irq", 64'(irq), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    read_check(3'd0, 32'h0, "arst_ctrl");
    read_check(3'd2, 32'h0, "arst_step");
    read_check(3'd1, 32'(RST_WORD), "arst_start_freq");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
